// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Op encodings, FSM states and default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 16;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
// Produces the HI/LO pair for one op plus a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvs_s;
  logic [31:0] dvs_u;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  // Low 64 bits of a sign-extended product equal the signed product.
  assign prod_s = {{32{src_a[31]}}, src_a}
                * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  assign b_zero = (src_b == 32'd0);
  assign mag_a  = src_a[31] ? -src_a : src_a;
  assign mag_b  = src_b[31] ? -src_b : src_b;
  assign dvs_s  = b_zero ? 32'd1 : mag_b;
  assign dvs_u  = b_zero ? 32'd1 : src_b;

  assign q_mag = mag_a / dvs_s;
  assign r_mag = mag_a % dvs_s;
  assign q_s   = (src_a[31] ^ src_b[31]) ? -q_mag : q_mag;
  assign r_s   = src_a[31] ? -r_mag : r_mag;
  assign q_u   = src_a / dvs_u;
  assign r_u   = src_a % dvs_u;

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    unique case (op)
      MDU_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDU_DIV: begin
        res_hi   = r_s;
        res_lo   = q_s;
        div_zero = b_zero;
      end
      MDU_DIVU: begin
        res_hi   = r_u;
        res_lo   = q_u;
        div_zero = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency FSM around mdu_arith.
// Results are staged in pend_* and committed to HI/LO on completion.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD =
    CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD =
    CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;

  mdu_arith u_arith (
    .op       (mdu_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (mdu_op)
            MDU_MULT, MDU_MULTU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              pend_dz_d = 1'b0;
              cnt_d     = MULT_LOAD;
              state_d   = ST_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              pend_dz_d = div_zero;
              cnt_d     = DIV_LOAD;
              state_d   = ST_RUN;
            end
            MDU_MTHI: hi_d = src_a;
            MDU_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          // A divide by zero burns its cycles but leaves HI/LO alone.
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the execute stage. Consumes the same A/B operand pair that the ALU operand mux delivers, and implements mult, multu, div, divu, mthi and mtlo. Results go into architectural HI/LO registers. Long operations hold `busy` for a fixed latency so the pipeline controller can stall dependent instructions.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration of mult/multu, in cycles (≥1).
- `DIV_CYCLES`, default 10: busy duration of div/divu, in cycles (≥1).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: issue strobe; `mdu_op` and both operands are sampled on the edge where `start`=1.
- `mdu_op`  in  4: operation select.
  - 0 = NONE
  - 1 = MULT
  - 2 = MULTU
  - 3 = DIV
  - 4 = DIVU
  - 5 = MTHI
  - 6 = MTLO
  - 7–15 = treated as NONE.
- `src_a`  in  32: rs operand (dividend, multiplicand, or mthi/mtlo data).
- `src_b`  in  32: rt operand (divisor, multiplier).
- `busy`  out  1: a multiply/divide is in flight.
- `hi`  out  32: architectural HI, registered.
- `lo`  out  32: architectural LO, registered.

## Operation
- Reset: `busy`=0, `hi`=0, `lo`=0, counter=0, pending result cleared.
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, down-counter active.
- IDLE + `start` + MULT/MULTU/DIV/DIVU:
  - Compute the result from the sampled operands into `pend_hi`/`pend_lo`.
  - Load counter with N−1, where N = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN:
  - Decrement the counter each cycle.
  - On the edge where the counter is 0: copy `pend_hi`/`pend_lo` to `hi`/`lo` and return to IDLE.
- IDLE + `start` + MTHI: `hi` ← `src_a` at that edge; `lo` unchanged; `busy` stays 0.
- IDLE + `start` + MTLO: `lo` ← `src_a` at that edge; `hi` unchanged; `busy` stays 0.
- `start` while `busy`=1: ignored entirely, including MTHI/MTLO. The controller must stall instead of issuing.
- Arithmetic rules:
  - MULT: 64-bit two's-complement product; {hi,lo} = product.
  - MULTU: 64-bit unsigned product; {hi,lo} = product.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient in lo, unsigned remainder in hi.
  - Divide by zero (DIV or DIVU): the full busy period still runs; at completion `hi`/`lo` keep their previous values.
- Reset asserted mid-operation: return to IDLE immediately at that edge, with the pending result discarded and all outputs set to their reset values.

## Timing
- Issue edge E:
  - `busy`=1 from E through E+N−1, i.e. exactly N cycles.
  - `hi`/`lo` take the new values after edge E+N, and `busy`=0 in that same cycle.
- A back-to-back issue is accepted at edge E+N, the first cycle `busy` reads 0.
- MTHI/MTLO take effect one edge after issue, with zero busy cycles.
- `hi`/`lo` are pure register outputs with no combinational path from any input.
- `busy` depends only on state, not on `start`. The hazard unit must combine `start` with `busy` itself to stall on the issue cycle.

## Structure
- Shared package `mdu_pkg` holds:
  - the `mdu_op` encodings (MDU_NONE … MDU_MTLO);
  - the state encoding (IDLE, RUN);
  - default latency constants.
- Sub-module `mdu_arith`: purely combinational. Maps op, src_a, src_b to {res_hi, res_lo, div_zero}.
- The top level holds the FSM, counter, pending registers and HI/LO.

## Test plan
- Reset then MULT, src_a=0xFFFFFFFE (−2), src_b=3:
  - `busy` high 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF×0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV −7 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 7 / 0 with prior hi=0x11, lo=0x22: busy 10 cycles, hi/lo stay 0x11/0x22.
- Busy and reset handling:
  - MTHI 0xABCD issued during DIVU busy: ignored.
  - MTLO 0x1234 issued in IDLE: lo=0x1234 next cycle.
  - `reset` asserted 3 cycles into a MULT: `busy`=0, hi=lo=0 next cycle, and a later MULT still runs correctly.
